// File: rtl/countdown_pkg.sv
// Shared state encodings for the countdown timer and its prescaler.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one tick every PRESCALE enabled cycles; tick is combinational off the held count.
// Latency: first tick PRESCALE enabled cycles after clr. No backpressure; en freezes the count.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled ticks, one-cycle done pulse and combinational zero flag.
// Latency: first decrement PRESCALE cycles after start; periodic mode when AUTO_RELOAD_EN is defined.
// No backpressure: load > stop > start strobes are sampled every edge.
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  import countdown_pkg::*;

  state_t state;
  logic   tick;
  logic   pre_en;

  // Gate on stop too, so the prescaler freezes on the same edge as the count.
  assign pre_en = (state == ST_RUN) && !stop;
  assign zero   = (count == '0);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (load),
    .tick (tick)
  );

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload <= '0;
    end else if (load) begin
      reload <= load_val;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count <= load_val;
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!stop && start) begin
              if (count != '0) begin
                state <= ST_RUN;
                busy  <= 1'b1;
              end else begin
                state <= ST_EXPIRED;
                done  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (stop) begin
              state <= ST_HOLD;
              busy  <= 1'b0;
            end else if (tick) begin
              if (count <= WIDTH'(1)) begin
                done <= 1'b1;
`ifdef AUTO_RELOAD_EN
                if (reload != '0) begin
                  count <= reload;
                end else begin
                  count <= '0;
                  state <= ST_EXPIRED;
                  busy  <= 1'b0;
                end
`else
                count <= '0;
                state <= ST_EXPIRED;
                busy  <= 1'b0;
`endif
              end else begin
                count <= count - WIDTH'(1);
              end
            end
          end
          ST_HOLD: begin
            if (!stop && start) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
          default: begin
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: one DUT at PRESCALE=1 and one at PRESCALE=4, hand-computed expectations.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       a_load, a_start, a_stop;
  logic [7:0] a_val;
  logic [7:0] a_count;
  logic       a_busy, a_done, a_zero;
  logic       b_load, b_start, b_stop;
  logic [7:0] b_val;
  logic [7:0] b_count;
  logic       b_busy, b_done, b_zero;

  int checks = 0;
  int errors = 0;
  int dones;

  countdown_timer #(.WIDTH(8), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .load(a_load), .load_val(a_val), .start(a_start), .stop(a_stop),
    .count(a_count), .busy(a_busy), .done(a_done), .zero(a_zero)
  );

  countdown_timer #(.WIDTH(8), .PRESCALE(4)) u_b (
    .clk(clk), .rst(rst), .load(b_load), .load_val(b_val), .start(b_start), .stop(b_stop),
    .count(b_count), .busy(b_busy), .done(b_done), .zero(b_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_load = 0; a_start = 0; a_stop = 0; a_val = '0;
    b_load = 0; b_start = 0; b_stop = 0; b_val = '0;
    #12;
    check("rst_count", a_count, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_zero", a_zero, 1);
    check("rst_b_count", b_count, 0);
    step(1); rst = 1'b0;
    step(1);
    check("post_rst_count", a_count, 0);
    check("post_rst_zero", a_zero, 1);
    check("post_rst_busy", a_busy, 0);

`ifndef AUTO_RELOAD_EN
    // PRESCALE=1: 3,2,1,0 on successive edges
    a_load = 1; a_val = 8'd3; step(1); a_load = 0;
    check("t1_load_count", a_count, 3);
    check("t1_load_busy", a_busy, 0);
    a_start = 1; step(1); a_start = 0;
    check("t1_start_count", a_count, 3);
    check("t1_start_busy", a_busy, 1);
    step(1); check("t1_c2", a_count, 2); check("t1_d2", a_done, 0);
    step(1); check("t1_c1", a_count, 1); check("t1_d1", a_done, 0);
    step(1); check("t1_c0", a_count, 0); check("t1_done", a_done, 1);
    check("t1_busy0", a_busy, 0); check("t1_zero", a_zero, 1);
    step(1); check("t1_done_drop", a_done, 0); check("t1_hold0", a_count, 0);

    // PRESCALE=4: decrement 4 cycles after start, done 8 cycles after start
    b_load = 1; b_val = 8'd2; step(1); b_load = 0;
    b_start = 1; step(1); b_start = 0;
    check("t2_start_count", b_count, 2); check("t2_busy", b_busy, 1);
    step(3); check("t2_c3", b_count, 2);
    step(1); check("t2_c4", b_count, 1);
    step(3); check("t2_c7", b_count, 1); check("t2_d7", b_done, 0);
    step(1); check("t2_c8", b_count, 0); check("t2_done8", b_done, 1);
    check("t2_busy8", b_busy, 0);
    step(1); check("t2_done9", b_done, 0);

    // stop after two ticks, hold, resume
    a_load = 1; a_val = 8'd5; step(1); a_load = 0;
    a_start = 1; step(1); a_start = 0;
    check("t3_c5", a_count, 5);
    step(2); check("t3_c3", a_count, 3);
    a_stop = 1; step(1); a_stop = 0;
    check("t3_stop_count", a_count, 3); check("t3_stop_busy", a_busy, 0);
    step(10);
    check("t3_hold_count", a_count, 3); check("t3_hold_done", a_done, 0);
    a_start = 1; step(1); a_start = 0;
    check("t3_resume_busy", a_busy, 1); check("t3_resume_count", a_count, 3);
    a_start = 1; a_stop = 1; step(1); a_start = 0; a_stop = 0;
    check("t3_stopwins_busy", a_busy, 0); check("t3_stopwins_count", a_count, 3);
    a_start = 1; step(1); a_start = 0;
    check("t3_resume2_busy", a_busy, 1);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (a_done === 1'b1) dones++;
    end
    check("t3_done_count", dones, 1);
    check("t3_end_count", a_count, 0); check("t3_end_busy", a_busy, 0);
`else
    // periodic mode: 2,1,2,1 with done every second cycle
    a_load = 1; a_val = 8'd2; step(1); a_load = 0;
    a_start = 1; step(1); a_start = 0;
    check("ar_c2a", a_count, 2); check("ar_busy_a", a_busy, 1);
    step(1); check("ar_c1a", a_count, 1); check("ar_d1a", a_done, 0);
    step(1); check("ar_c2b", a_count, 2); check("ar_d2b", a_done, 1); check("ar_busy_b", a_busy, 1);
    step(1); check("ar_c1b", a_count, 1); check("ar_d1b", a_done, 0);
    step(1); check("ar_c2c", a_count, 2); check("ar_d2c", a_done, 1); check("ar_busy_c", a_busy, 1);
`endif

    // load 0 then start: immediate expiry, later start ignored
    a_load = 1; a_val = 8'd0; step(1); a_load = 0;
    check("t4_zero", a_zero, 1);
    a_start = 1; step(1); a_start = 0;
    check("t4_done", a_done, 1); check("t4_busy", a_busy, 0);
    step(1); check("t4_done_drop", a_done, 0);
    a_start = 1; step(1); a_start = 0;
    check("t4_restart_done", a_done, 0); check("t4_restart_busy", a_busy, 0);
    step(1); check("t4_restart_done2", a_done, 0);
    a_load = 1; a_val = 8'd7; step(1); a_load = 0;
    check("t4_load7", a_count, 7); check("t4_load7_zero", a_zero, 0);
    check("t4_load7_busy", a_busy, 0);

    // load and start together: load wins
    a_load = 1; a_start = 1; a_val = 8'd4; step(1); a_load = 0; a_start = 0;
    check("t5_count", a_count, 4); check("t5_busy", a_busy, 0);
    step(1); check("t5_idle_count", a_count, 4);

    // async reset mid-count
    a_start = 1; step(1); a_start = 0;
    step(1); check("t6_pre_rst", a_count, 3);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_count", a_count, 0); check("t6_rst_busy", a_busy, 0);
    check("t6_rst_done", a_done, 0); check("t6_rst_zero", a_zero, 1);
    step(1); rst = 1'b0;
    step(1); check("t6_after_count", a_count, 0); check("t6_after_done", a_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
